// File: rtl/alu_pkg.sv
// Shared ALU constants: CLA group size, add/sub opcode encoding and the 4-bit group P/G helper.
package alu_pkg;

  localparam int unsigned CLA_GROUP = 4;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Returns {P, G} for one 4-bit group from per-bit propagate/generate.
  function automatic logic [1:0] cla_group_pg(input logic [CLA_GROUP-1:0] p,
                                              input logic [CLA_GROUP-1:0] g);
    logic grp_p;
    logic grp_g;
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {grp_p, grp_g};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: local carries, sum bits and group propagate/generate.
module cla_group4
  import alu_pkg::*;
(
  input  logic [CLA_GROUP-1:0] p_i,
  input  logic [CLA_GROUP-1:0] g_i,
  input  logic                 c_i,
  output logic [CLA_GROUP-1:0] sum_o,
  output logic                 p_o,
  output logic                 g_o
);

  logic [CLA_GROUP-1:0] c;

  always_comb begin
    c[0] = c_i;
    c[1] = g_i[0] | (p_i[0] & c_i);
    c[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    c[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0]) |
           (p_i[2] & p_i[1] & p_i[0] & c_i);
  end

  assign sum_o      = p_i ^ c;
  assign {p_o, g_o} = cla_group_pg(p_i, g_i);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: the carry chain is cut into STAGES registered segments,
// with valid/ready handshakes on both sides and carry/overflow/zero flags on the result.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned GROUPS = WIDTH / CLA_GROUP;
  localparam int unsigned SEG    = GROUPS / STAGES;
  localparam int unsigned SEG_W  = SEG * CLA_GROUP;
  localparam int unsigned LAST   = STAGES - 1;

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < 8 || STAGES < 1 || STAGES > GROUPS ||
      (GROUPS % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_cla_addsub: illegal WIDTH/STAGES combination");
  end

  logic [WIDTH-1:0]  b_mod;
  // x holds per-bit propagate for unresolved segments and final sum bits for resolved ones.
  logic [WIDTH-1:0]  x_src [STAGES];
  logic [WIDTH-1:0]  g_src [STAGES];
  logic [WIDTH-1:0]  x_d   [STAGES];
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  g_q   [STAGES];
  logic [STAGES-1:0] v_src, c_src, c_d, v_q, c_q, adv;
  logic              ovf_d, zero_d, ovf_q, zero_q;

  assign b_mod = (in_sub == ALU_OP_ADD) ? in_b : ~in_b;

  always_comb begin
    v_src    = v_q << 1;
    v_src[0] = in_valid;
    c_src    = c_q << 1;
    c_src[0] = (in_sub == ALU_OP_SUB) ? 1'b1 : in_cin;
  end

  // A stage may load when it is empty or its content moves on in the same cycle.
  always_comb begin
    adv       = '0;
    adv[LAST] = ~v_q[LAST] | out_ready;
    for (int s = int'(LAST) - 1; s >= 0; s--) begin
      adv[s] = ~v_q[s] | adv[s+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * SEG_W;

    logic [SEG-1:0]   gp, gg;
    logic [SEG:0]     gc;
    logic [SEG_W-1:0] seg_sum;
    logic [WIDTH-1:0] x_seg;

    if (s == 0) begin : g_first
      assign x_src[s] = in_a ^ b_mod;
      assign g_src[s] = in_a & b_mod;
    end else begin : g_chain
      assign x_src[s] = x_q[s-1];
      assign g_src[s] = g_q[s-1];
    end

    for (genvar j = 0; j < SEG; j++) begin : g_grp
      cla_group4 u_grp (
        .p_i  (x_src[s][LO + CLA_GROUP*j +: CLA_GROUP]),
        .g_i  (g_src[s][LO + CLA_GROUP*j +: CLA_GROUP]),
        .c_i  (gc[j]),
        .sum_o(seg_sum[CLA_GROUP*j +: CLA_GROUP]),
        .p_o  (gp[j]),
        .g_o  (gg[j])
      );
    end

    // Group carries expanded as full lookahead sums of G/P products.
    always_comb begin
      logic run_g;
      logic run_p;
      run_g = 1'b0;
      run_p = 1'b1;
      gc    = '0;
      gc[0] = c_src[s];
      for (int j = 1; j <= int'(SEG); j++) begin
        run_g = 1'b0;
        run_p = 1'b1;
        for (int k = j - 1; k >= 0; k--) begin
          run_g = run_g | (run_p & gg[k]);
          run_p = run_p & gp[k];
        end
        gc[j] = run_g | (run_p & c_src[s]);
      end
    end

    always_comb begin
      x_seg              = x_src[s];
      x_seg[LO +: SEG_W] = seg_sum;
    end

    assign x_d[s] = x_seg;
    assign c_d[s] = gc[SEG];

    if (s == LAST) begin : g_flags
      // Carry into the MSB is recovered as sum[MSB] ^ p[MSB].
      assign ovf_d  = x_seg[WIDTH-1] ^ x_src[s][WIDTH-1] ^ gc[SEG];
      assign zero_d = ~|x_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        x_q[s] <= '0;
        g_q[s] <= '0;
      end
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (adv[s]) begin
          v_q[s] <= v_src[s];
          x_q[s] <= x_d[s];
          g_q[s] <= g_src[s];
          c_q[s] <= c_d[s];
        end
      end
      if (adv[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = x_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench: directed corners, backpressure, random stream against an arithmetic
// reference model, mid-flight reset, and corner cases on 32-bit/4-stage and 8-bit/1-stage builds.
module tb_pipelined_cla_addsub;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 2;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic             out_valid, out_ready, out_cout, out_ovf, out_zero;

  logic        alt_valid, alt_cin, alt_sub;
  logic [31:0] a32_a, a32_b, w32_sum;
  logic [7:0]  a8_a, a8_b, w8_sum;
  logic        w32_in_ready, w32_out_valid, w32_cout, w32_ovf, w32_zero;
  logic        w8_in_ready, w8_out_valid, w8_cout, w8_ovf, w8_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rx  = 0;
  res_t exp_q[$];

  pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_zero(out_zero)
  );

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(4)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(alt_valid), .in_ready(w32_in_ready), .in_a(a32_a),
    .in_b(a32_b), .in_cin(alt_cin), .in_sub(alt_sub), .out_valid(w32_out_valid),
    .out_ready(1'b1), .out_sum(w32_sum), .out_cout(w32_cout), .out_ovf(w32_ovf),
    .out_zero(w32_zero)
  );

  pipelined_cla_addsub #(.WIDTH(8), .STAGES(1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(alt_valid), .in_ready(w8_in_ready), .in_a(a8_a),
    .in_b(a8_b), .in_cin(alt_cin), .in_sub(alt_sub), .out_valid(w8_out_valid),
    .out_ready(1'b1), .out_sum(w8_sum), .out_cout(w8_cout), .out_ovf(w8_ovf),
    .out_zero(w8_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned sum for carry, signed sum range test for overflow.
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sub);
    res_t   r;
    longint m, half, ua, ub, sa, sb, ru, rs;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    if (sub) begin
      ru     = ua - ub;
      rs     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ru     = ua + ub + longint'(cin);
      rs     = sa + sb + longint'(cin);
      r.cout = (ru > m);
    end
    r.sum  = ru & m;
    r.ovf  = (rs >= half) || (rs < -half);
    r.zero = ((ru & m) == 0);
    return r;
  endfunction

  task automatic new_operands();
    in_a   = WIDTH'($urandom);
    in_b   = WIDTH'($urandom);
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  // Called at a falling edge with inputs set; resolves the coming rising edge, ends at next fall.
  task automatic cycle(output bit acc);
    bit   emit;
    res_t e;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_sum", 64'(out_sum), e.sum);
        check("sb_cout", 64'(out_cout), 64'(e.cout));
        check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
        check("sb_zero", 64'(out_zero), 64'(e.zero));
        n_rx++;
      end
    end
    if (acc) exp_q.push_back(ref_model(WIDTH, 64'(in_a), 64'(in_b), in_cin, in_sub));
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    int lat;
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    in_valid  = 1'b1;
    #1 check({tag, "_rdy"}, 64'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(STAGES));
    check({tag, "_sum"}, 64'(out_sum), 64'(es));
    check({tag, "_cout"}, 64'(out_cout), 64'(ec));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
    check({tag, "_zero"}, 64'(out_zero), 64'(ez));
    @(negedge clk);
  endtask

  task automatic alt_case(input logic [31:0] x32, input logic [31:0] y32, input logic [7:0] x8,
                          input logic [7:0] y8, input logic cin, input logic sub);
    res_t e32, e8;
    e32       = ref_model(32, 64'(x32), 64'(y32), cin, sub);
    e8        = ref_model(8, 64'(x8), 64'(y8), cin, sub);
    a32_a     = x32;
    a32_b     = y32;
    a8_a      = x8;
    a8_b      = y8;
    alt_cin   = cin;
    alt_sub   = sub;
    alt_valid = 1'b1;
    #1 check("alt_rdy", 64'({w32_in_ready, w8_in_ready}), 64'(2'b11));
    @(negedge clk);
    alt_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("w8_valid", 64'(w8_out_valid), 64'(k == 1));
      check("w32_valid", 64'(w32_out_valid), 64'(k == 4));
      if (k == 1) begin
        check("w8_sum", 64'(w8_sum), e8.sum);
        check("w8_flags", 64'({w8_cout, w8_ovf, w8_zero}), 64'({e8.cout, e8.ovf, e8.zero}));
      end
      if (k == 4) begin
        check("w32_sum", 64'(w32_sum), e32.sum);
        check("w32_flags", 64'({w32_cout, w32_ovf, w32_zero}),
              64'({e32.cout, e32.ovf, e32.zero}));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    int               n_acc, n_sent, rx0, stale;
    bit               have_held;
    logic [WIDTH-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    alt_valid = 1'b0;
    alt_cin   = 1'b0;
    alt_sub   = 1'b0;
    a32_a     = '0;
    a32_b     = '0;
    a8_a      = '0;
    a8_b      = '0;
    held      = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_sum", 64'(out_sum), 0);
    check("rst_flags", 64'({out_cout, out_ovf, out_zero}), 0);
    check("rst_alt_valid", 64'({w32_out_valid, w8_out_valid}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 1);

    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_cin_ign", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: consumer stalled for 6 cycles under continuous input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_operands();
    n_acc     = 0;
    have_held = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(acc);
      if (acc) begin
        n_acc++;
        new_operands();
      end
      if (out_valid) begin
        if (have_held) check("bp_hold", 64'(out_sum), 64'(held));
        held      = out_sum;
        have_held = 1'b1;
      end
    end
    check("bp_accepted", 64'(n_acc), 2);
    check("bp_in_ready", 64'(in_ready), 0);
    check("bp_out_valid", 64'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
    check("bp_drained", 64'(exp_q.size()), 0);

    // Random back-to-back stream with ~70% consumer readiness.
    rx0      = n_rx;
    n_sent   = 0;
    in_valid = 1'b1;
    new_operands();
    for (int c = 0; c < 3000 && n_sent < 200; c++) begin
      out_ready = ($urandom_range(0, 99) < 70);
      cycle(acc);
      if (acc) begin
        n_sent++;
        if (n_sent < 200) new_operands();
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
    check("rand_sent", 64'(n_sent), 200);
    check("rand_received", 64'(n_rx - rx0), 200);
    check("rand_drained", 64'(exp_q.size()), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_operands();
    cycle(acc);
    new_operands();
    cycle(acc);
    check("pre_rst_valid", 64'(out_valid), 1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_sum", 64'(out_sum), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) stale++;
      @(negedge clk);
    end
    check("post_rst_stale", 64'(stale), 0);
    directed("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b0);

    // Alternate builds: 32-bit/4-stage and 8-bit/1-stage.
    alt_case(32'h7FFF_FFFF, 32'h1, 8'h7F, 8'h01, 1'b0, 1'b0);
    alt_case(32'hFFFF_FFFF, 32'h1, 8'hFF, 8'h01, 1'b0, 1'b0);
    alt_case(32'h0000_FFFF, 32'h0, 8'h0F, 8'h00, 1'b1, 1'b0);
    alt_case(32'h5, 32'h7, 8'h05, 8'h07, 1'b0, 1'b1);
    alt_case(32'h8000_0000, 32'h1, 8'h80, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      alt_case($urandom, $urandom, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
